spike_rate_decoder: RTL and testbench

//  Receiving end of the neuron spike interface: turns a 1-bit spike train back into numbers.
//  - Windowed spike count (rate code) delivered over a valid/ready handshake.
//  - Continuous leaky synaptic trace (current reconstruction).

---
 rtl/spike_dec_pkg.sv | 14 +
 rtl/spike_trace.sv | 34 +++
 rtl/spike_rate_decoder.sv | 167 ++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder slice.
package spike_dec_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} dec_state_t;

    // Unsigned add clamped to max; callers narrow the result to their own width.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/spike_trace.sv
// Leaky synaptic trace: each enabled cycle the trace decays by a right shift and
// gains TRACE_INC on a spike, saturating at the top of its range.
module spike_trace
    import spike_dec_pkg::*;
#(
    parameter int unsigned TRACE_W     = 8,
    parameter int unsigned TRACE_INC   = 64,
    parameter int unsigned DECAY_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               spike_in,
    output logic [TRACE_W-1:0] trace
);

    localparam int unsigned TraceMax = 32'((64'd1 << TRACE_W) - 1);

    logic [TRACE_W-1:0] trace_d;

    always_comb begin
        trace_d = trace;
        if (en) begin
            trace_d = TRACE_W'(sat_add(32'(trace >> DECAY_SHIFT),
                                       spike_in ? TRACE_INC : 32'd0, TraceMax));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) trace <= '0;
        else        trace <= trace_d;
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train decoder: windowed spike count over valid/ready plus a leaky synaptic trace.
// Defining SPIKE_DEC_ISI_EN adds last inter-spike interval tracking (isi_last/isi_valid).
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int unsigned WINDOW      = 16,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned TRACE_W     = 8,
    parameter int unsigned TRACE_INC   = 64,
    parameter int unsigned DECAY_SHIFT = 1
`ifdef SPIKE_DEC_ISI_EN
    ,
    parameter int unsigned ISI_W       = 8
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               spike_in,
    input  logic               start,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [CNT_W-1:0]   rate,
    output logic               overflow,
    output logic               busy,
    output logic [TRACE_W-1:0] trace
`ifdef SPIKE_DEC_ISI_EN
    ,
    output logic [ISI_W-1:0]   isi_last,
    output logic               isi_valid
`endif
);

    localparam int unsigned WinW   = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int unsigned CntMax = 32'((64'd1 << CNT_W) - 1);

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
    logic [WinW-1:0]  win_q, win_d;
    logic             ovf_q, ovf_d, ovf_hit;
    logic             out_valid_d, overflow_d;
    logic [CNT_W-1:0] rate_d;

    spike_trace #(
        .TRACE_W    (TRACE_W),
        .TRACE_INC  (TRACE_INC),
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_trace (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .spike_in(spike_in),
        .trace   (trace)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
        end
    end

    // HOLD always has out_valid high, so out_ready alone is the accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && en) state_d = COUNT;
            COUNT:   if (en && win_q == '0) state_d = HOLD;
            HOLD:    if (out_ready) state_d = (start && en) ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        win_d       = win_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid;
        rate_d      = rate;
        overflow_d  = overflow;
        cnt_sat     = CNT_W'(sat_add(32'(cnt_q), 32'(spike_in), CntMax));
        ovf_hit     = spike_in && (32'(cnt_q) == CntMax);
        unique case (state_q)
            IDLE: begin
                if (start && en) begin
                    cnt_d      = '0;
                    win_d      = WinW'(WINDOW - 1);
                    ovf_d      = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            COUNT: begin
                if (en) begin
                    if (win_q == '0) begin
                        rate_d      = cnt_sat;
                        overflow_d  = ovf_q | ovf_hit;
                        out_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_sat;
                        ovf_d = ovf_q | ovf_hit;
                        win_d = win_q - WinW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start && en) begin
                        cnt_d      = '0;
                        win_d      = WinW'(WINDOW - 1);
                        ovf_d      = 1'b0;
                        overflow_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            win_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            rate      <= '0;
            overflow  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            ovf_q     <= ovf_d;
            out_valid <= out_valid_d;
            rate      <= rate_d;
            overflow  <= overflow_d;
        end
    end

`ifdef SPIKE_DEC_ISI_EN
    localparam int unsigned IsiMax = 32'((64'd1 << ISI_W) - 1);

    logic [ISI_W-1:0] isi_cnt;
    logic             isi_seen;

    // The first spike after reset only arms tracking; intervals are reported from the second.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isi_cnt   <= '0;
            isi_seen  <= 1'b0;
            isi_last  <= '0;
            isi_valid <= 1'b0;
        end else if (en) begin
            if (spike_in) begin
                isi_last  <= isi_cnt;
                isi_valid <= isi_valid | isi_seen;
                isi_seen  <= 1'b1;
                isi_cnt   <= ISI_W'(1);
            end else begin
                isi_cnt <= ISI_W'(sat_add(32'(isi_cnt), 32'd1, IsiMax));
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench: two decoder instances (default, and CNT_W=3/TRACE_INC=200) share stimulus
// and are compared every cycle against a window/trace reference model; ISI checks need SPIKE_DEC_ISI_EN.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n, en, spike_in, start, out_ready;
    logic       ov0, ov1, of0, of1, b0, b1;
    logic [4:0] rate0;
    logic [2:0] rate1;
    logic [7:0] tr0, tr1;
`ifdef SPIKE_DEC_ISI_EN
    logic [7:0] isi0, isi1;
    logic       iv0, iv1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spike_rate_decoder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in), .start(start),
        .out_ready(out_ready), .out_valid(ov0), .rate(rate0), .overflow(of0), .busy(b0),
        .trace(tr0)
`ifdef SPIKE_DEC_ISI_EN
        , .isi_last(isi0), .isi_valid(iv0)
`endif
    );

    spike_rate_decoder #(.CNT_W(3), .TRACE_INC(200)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in), .start(start),
        .out_ready(out_ready), .out_valid(ov1), .rate(rate1), .overflow(of1), .busy(b1),
        .trace(tr1)
`ifdef SPIKE_DEC_ISI_EN
        , .isi_last(isi1), .isi_valid(iv1)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: unbounded window count clamped only when the window closes.
    localparam int Window = 16;
    int m_trace[2], m_st[2], m_cnt[2], m_left[2], m_rate[2], m_ovf[2], m_valid[2];
    int m_isi_cnt, m_isi_last, m_isi_seen, m_isi_valid;

    function automatic int cnt_max(input int i);
        return (i == 0) ? 31 : 7;
    endfunction

    function automatic int tr_inc(input int i);
        return (i == 0) ? 64 : 200;
    endfunction

    task automatic open_window(input int i);
        m_st[i]   = 1;
        m_cnt[i]  = 0;
        m_left[i] = Window;
        m_ovf[i]  = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_trace[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
                m_rate[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
            end else begin
                if (en) begin
                    m_trace[i] = m_trace[i] / 2 + (spike_in ? tr_inc(i) : 0);
                    if (m_trace[i] > 255) m_trace[i] = 255;
                end
                case (m_st[i])
                    0: if (start && en) open_window(i);
                    1: if (en) begin
                        m_cnt[i] += int'(spike_in);
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_rate[i]  = (m_cnt[i] > cnt_max(i)) ? cnt_max(i) : m_cnt[i];
                            m_ovf[i]   = int'(m_cnt[i] > cnt_max(i));
                            m_valid[i] = 1;
                            m_st[i]    = 2;
                        end
                    end
                    default: if (out_ready) begin
                        m_valid[i] = 0;
                        if (start && en) open_window(i);
                        else m_st[i] = 0;
                    end
                endcase
            end
        end
        if (!rst_n) begin
            m_isi_cnt = 0; m_isi_last = 0; m_isi_seen = 0; m_isi_valid = 0;
        end else if (en) begin
            if (spike_in) begin
                m_isi_last  = m_isi_cnt;
                m_isi_valid = m_isi_seen;
                m_isi_seen  = 1;
                m_isi_cnt   = 1;
            end else if (m_isi_cnt < 255) begin
                m_isi_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        check("valid0", int'(ov0), m_valid[0]);
        check("rate0", int'(rate0), m_rate[0]);
        check("ovf0", int'(of0), m_ovf[0]);
        check("busy0", int'(b0), int'(m_st[0] != 0));
        check("trace0", int'(tr0), m_trace[0]);
        check("valid1", int'(ov1), m_valid[1]);
        check("rate1", int'(rate1), m_rate[1]);
        check("ovf1", int'(of1), m_ovf[1]);
        check("busy1", int'(b1), int'(m_st[1] != 0));
        check("trace1", int'(tr1), m_trace[1]);
`ifdef SPIKE_DEC_ISI_EN
        check("isi_last0", int'(isi0), m_isi_last);
        check("isi_valid0", int'(iv0), m_isi_valid);
        check("isi_last1", int'(isi1), m_isi_last);
        check("isi_valid1", int'(iv1), m_isi_valid);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; spike_in = 1'b0; start = 1'b0; out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int t2[10];
        t2 = '{64, 96, 112, 120, 124, 126, 127, 127, 127, 127};

        // Reset state and single-spike decay
        do_reset();
        check("rst_valid", int'(ov0), 0);
        check("rst_busy", int'(b0), 0);
        check("rst_trace", int'(tr0), 0);
        check("rst_rate", int'(rate0), 0);
        en = 1'b1; spike_in = 1'b1;
        cycle();
        check("t1_trace", int'(tr0), 64);
        spike_in = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            check("t1_decay", int'(tr0), 64 >> (k + 1));
        end

        // Continuous spiking; the second instance saturates
        do_reset();
        en = 1'b1; spike_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("t2_trace", int'(tr0), t2[k]);
            if (k == 0) check("t3_trace", int'(tr1), 200);
            if (k == 1) check("t3_sat", int'(tr1), 255);
        end

        // 5 spikes in one window; the start-cycle spike is excluded
        do_reset();
        en = 1'b1; start = 1'b1; spike_in = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            spike_in = (j == 1 || j == 4 || j == 8 || j == 12 || j == 16);
            cycle();
            if (j == 15) check("t4_early", int'(ov0), 0);
        end
        check("t4_valid", int'(ov0), 1);
        check("t4_rate", int'(rate0), 5);
        check("t4_ovf", int'(of0), 0);
        spike_in = 1'b0;
        cycle();
        check("t4_pulse", int'(ov0), 0);
        check("t4_keep", int'(rate0), 5);

        // Saturating window, long hold with start ignored, back-to-back restart
        do_reset();
        en = 1'b1; start = 1'b1; spike_in = 1'b1;
        cycle();
        start = 1'b0;
        for (int j = 0; j < 16; j++) cycle();
        check("t5_rate", int'(rate1), 7);
        check("t5_ovf", int'(of1), 1);
        start = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cycle();
            check("t5_hold_valid", int'(ov1), 1);
            check("t5_hold_rate", int'(rate1), 7);
        end
        out_ready = 1'b1;
        cycle();
        check("t5_b2b_valid", int'(ov1), 0);
        check("t5_b2b_busy", int'(b1), 1);
        check("t5_b2b_ovf", int'(of1), 0);
        check("t5_b2b_rate", int'(rate1), 7);

        // Window stretched by en=0; spikes while disabled are not counted
        do_reset();
        en = 1'b1; start = 1'b1; out_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            en = !(j >= 6 && j < 10);
            spike_in = (j >= 6 && j < 10) || j == 2 || j == 15;
            cycle();
            if (j == 15) check("t6_stretch", int'(ov0), 0);
        end
        check("t6_valid", int'(ov0), 1);
        check("t6_rate", int'(rate0), 2);

        // Reset mid-window aborts the result
        do_reset();
        en = 1'b1; start = 1'b1; spike_in = 1'b1;
        cycle();
        start = 1'b0;
        for (int j = 0; j < 5; j++) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            cycle();
            check("t6_abort", int'(ov0), 0);
        end

`ifdef SPIKE_DEC_ISI_EN
        do_reset();
        en = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            spike_in = (j == 3 || j == 10);
            cycle();
            if (j == 3) check("t7_first", int'(iv0), 0);
        end
        check("t7_isi", int'(isi0), 7);
        check("t7_valid", int'(iv0), 1);
        do_reset();
        en = 1'b1; spike_in = 1'b1;
        cycle();
        spike_in = 1'b0;
        for (int j = 0; j < 8; j++) cycle();
        check("t7_single", int'(iv0), 0);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 9) != 0);
            spike_in  = (n % 400 < 60) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
            start     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
